serial_frame_tx: RTL
====================

# serial_frame_tx

Upstream serializer for the serial demultiplexer. Accepts bytes tagged with a 2-bit destination port through a valid/ready interface and buffers them in a small FIFO. It then drives the single-bit serial line `SE_out` that feeds the demux controller's `SE_in`. Each frame is one start bit (0), two address bits, and one or more 8-bit bytes, with a continuation bit after every byte (0 = another byte follows, 1 = stop).

## Interface
- `DEPTH`, 4: FIFO depth in bytes. Power of two, at least 2.
- `IDLE_GAP`, 1: minimum number of idle-high cycles between frames. At least 1.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  a byte is offered this cycle.
- `wr_ready`  out  1  FIFO can accept a byte (FIFO not full).
- `wr_addr`  in  2  destination port. Only meaningful on the first byte of a frame.
- `wr_data`  in  8  byte to send.
- `wr_last`  in  1  this byte ends its frame.
- `SE_out`  out  1  serial line. Idle is high.
- `busy`  out  1  a frame is in progress (from start bit through stop bit).
- `underrun`  out  1  one-cycle pulse: a frame was cut short because the FIFO was empty.

## Operation
- **Write:** a byte is accepted when `wr_valid && wr_ready`. The stored entry is {addr, last, data}, 11 bits.
- **Last counter:** `last_cnt` counts the entries in the FIFO that have `last=1`.
- **Simultaneous push and pop:** both happen in the same cycle. Count is unchanged and `wr_ready` is not affected by the pop.
- **State machine:** IDLE, START, ADDR1, ADDR0, DATA, CONT, GAP.
- **IDLE:** `SE_out=1`. Leave for START when `last_cnt>0` or the FIFO is full. On leaving, pop the head entry into the shift register and latch its addr.
- **START:** `SE_out=0` for one cycle.
- **ADDR1, ADDR0:** `SE_out` = addr[1], then addr[0]. Address is sent MSB first.
- **DATA:** 8 cycles, data[7] first, bit counter counting 7 down to 0.
- **CONT (one cycle):**
  - If the current byte has last=1: `SE_out=1`, go to GAP.
  - Else if the FIFO is non-empty: `SE_out=0`, pop the next byte into the shift register, go to DATA. Its addr field is ignored.
  - Else (empty): `SE_out=1`, pulse `underrun`, go to GAP. The rest of that frame's bytes start a new frame later, using the addr stored in their entry.
- **GAP:** `SE_out=1` for `IDLE_GAP` cycles, then IDLE. IDLE is also high, so the line is high for at least `IDLE_GAP+1` cycles between frames.
- **Busy:** `busy` = 1 in states START through CONT.
- **Reset:** clears everything, including mid-frame; a partially sent frame is abandoned.
  - FIFO empty, `last_cnt`=0, state IDLE.
  - `SE_out`=1, `busy`=0, `underrun`=0, `wr_ready`=1.

## Timing
- `SE_out`, `busy` and `underrun` are registered; they reflect the current state.
- **Start latency:** if the last byte of a frame is written at cycle T (and the block is in IDLE), the start bit appears at T+2. The entry becomes visible at T+1, IDLE sees the condition and goes to START, and START is on the line at T+2.
- **Frame layout:** an N-byte frame occupies 3+9N cycles, start bit to stop bit inclusive.
  - Cycle 0: start bit. Cycles 1–2: addr.
  - Byte k (k = 0..N-1): data bits at cycles 3+9k to 10+9k, continuation bit at 11+9k.
- **Downstream alignment:** this matches the demux controller's sequence sh1, sh2, D1–D8, Stop_cont. That controller samples its start bit in Wait.
- **Mid-frame writes:** allowed at any time. A byte written by cycle C−1 is visible to a CONT at cycle C.
- **Full FIFO:** `wr_ready=0` and writes are ignored. A full FIFO with no last entry still starts a frame, which prevents deadlock on frames longer than `DEPTH`.

## Test plan
- **Reset:** hold `reset` for 2 cycles → `SE_out=1`, `busy=0`, `wr_ready=1`, `underrun=0`. Apply `reset` mid-DATA → `SE_out=1` on the next cycle and the FIFO is empty.
- **Single-byte frame:** write addr=2'b10, data=8'hA5, last=1 at T.
  - Start bit at T+2, then 1,0, then 1,0,1,0,0,1,0,1, then stop bit 1.
  - `busy` high for 12 cycles; line high for at least `IDLE_GAP+1` cycles after the stop bit.
- **Multi-byte frame:** write 3 bytes to addr=2'b01 (8'h00, 8'hFF, 8'h3C last) → 30-cycle frame with continuation bits 0, 0, 1 at offsets 11, 20, 29.
- **Underrun:** write 8'h11 (last=0), then hold `wr_valid` low → stop bit 1 at offset 11 and `underrun` pulses in that cycle. A later write of 8'h22 last=1 produces a new frame using 8'h22's own addr.
- **Full and long frame:** with `DEPTH`=4, write 6 non-last bytes back-to-back, then a last byte.
  - `wr_ready` falls after 4 writes; the frame starts with no last byte present.
  - All 7 bytes go out in one 66-cycle frame if writes keep pace, with no overflow and no lost bytes.
- **Back-to-back frames:** two complete frames queued → exactly `IDLE_GAP+1` high cycles between frame 1's stop bit and frame 2's start bit, and frame 2's addr matches its first entry.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Write-side valid/ready bundle for serial_frame_tx: one byte plus its destination
// port and end-of-frame flag per transfer.
interface serial_frame_tx_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_last;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Byte FIFO feeding a start/addr/data/continuation serializer on SE_out.
// Frames start when a complete frame is queued or the FIFO fills.
module serial_frame_tx #(
    parameter int DEPTH    = 4,
    parameter int IDLE_GAP = 1
) (
    input  logic               clock,
    input  logic               reset,
    serial_frame_tx_if.slave   wr,
    output logic               SE_out,
    output logic               busy,
    output logic               underrun
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR1,
        S_ADDR0,
        S_DATA,
        S_CONT,
        S_GAP
    } state_t;

    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_last_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [10:0]   w_head;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_last_cnt_nxt;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [1:0]    r_addr;
    logic [1:0]    w_addr_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_nxt;

    logic          r_se;
    logic          r_busy;
    logic          r_und;
    logic          w_se_nxt;
    logic          w_busy_nxt;
    logic          w_und_nxt;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = wr.wr_valid && !w_full;
    assign w_head      = r_mem[r_rptr];
    assign wr.wr_ready = !w_full;

    always_comb begin
        w_count_nxt    = r_count;
        w_last_cnt_nxt = r_last_cnt;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CW'(1);
        if ((w_push && wr.wr_last) && !(w_pop && w_head[8]))
            w_last_cnt_nxt = r_last_cnt + CW'(1);
        else if (!(w_push && wr.wr_last) && (w_pop && w_head[8]))
            w_last_cnt_nxt = r_last_cnt - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= {wr.wr_addr, wr.wr_last, wr.wr_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_last_cnt <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count    <= w_count_nxt;
            r_last_cnt <= w_last_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_addr_nxt  = r_addr;
        w_last_nxt  = r_last;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_last_cnt != '0 || w_full) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head[7:0];
                    w_addr_nxt  = w_head[10:9];
                    w_last_nxt  = w_head[8];
                    w_state_nxt = S_START;
                end
            end
            S_START: w_state_nxt = S_ADDR1;
            S_ADDR1: w_state_nxt = S_ADDR0;
            S_ADDR0: begin
                w_bit_nxt   = 3'd7;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_bit == 3'd0) begin
                    w_state_nxt = S_CONT;
                end else begin
                    w_shift_nxt = {r_shift[6:0], 1'b0};
                    w_bit_nxt   = r_bit - 3'd1;
                end
            end
            S_CONT: begin
                if (!r_last && !w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head[7:0];
                    w_last_nxt  = w_head[8];
                    w_bit_nxt   = 3'd7;
                    w_state_nxt = S_DATA;
                end else begin
                    w_gap_nxt   = GW'(IDLE_GAP - 1);
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_gap_nxt = r_gap - GW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so the registered line
    // matches the state it belongs to; the CONT decision uses the FIFO count
    // that CONT itself will see (no pop ever precedes CONT by one cycle).
    always_comb begin
        w_se_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_und_nxt  = 1'b0;
        case (w_state_nxt)
            S_START: begin
                w_se_nxt   = 1'b0;
                w_busy_nxt = 1'b1;
            end
            S_ADDR1: begin
                w_se_nxt   = w_addr_nxt[1];
                w_busy_nxt = 1'b1;
            end
            S_ADDR0: begin
                w_se_nxt   = w_addr_nxt[0];
                w_busy_nxt = 1'b1;
            end
            S_DATA: begin
                w_se_nxt   = w_shift_nxt[7];
                w_busy_nxt = 1'b1;
            end
            S_CONT: begin
                w_busy_nxt = 1'b1;
                if (!w_last_nxt) begin
                    if (w_count_nxt != '0)
                        w_se_nxt = 1'b0;
                    else
                        w_und_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_se    <= 1'b1;
            r_busy  <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_addr  <= w_addr_nxt;
            r_last  <= w_last_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_se    <= w_se_nxt;
            r_busy  <= w_busy_nxt;
            r_und   <= w_und_nxt;
        end
    end

    assign SE_out   = r_se;
    assign busy     = r_busy;
    assign underrun = r_und;
endmodule
